// File: rtl/pipe_credit_buf.sv
// pipe_credit_buf: credit-managed FWFT buffer for a fixed-delay pipe (issue/credit_ok/credit_cnt upstream, in_vld/in_data from pipe, out_vld/out_rdy/out_data/count to consumer, sticky ovf_err)
module pipe_credit_buf #(
  parameter int DEPTH = 4,
  parameter int WID = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  output logic             credit_ok,
  output logic [CNT_W-1:0] credit_cnt,
  input  logic             in_vld,
  input  logic [WID-1:0]   in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WID-1:0]   out_data,
  output logic [CNT_W-1:0] count,
  output logic             ovf_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  logic [WID-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, credit_q, credit_d;
  logic ovf_q, ovf_d, push, pop, drop, issue_ok, sat;
  always_comb begin
    pop = count_q != '0 && out_rdy;
    push = in_vld && (count_q != FULL || pop);
    drop = in_vld && !push;
    issue_ok = issue && credit_q != '0;
    sat = pop && !issue_ok && credit_q == FULL;
    rd_ptr_d = pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    wr_ptr_d = push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    credit_d = sat ? credit_q : credit_q + CNT_W'(pop) - CNT_W'(issue_ok);
    ovf_d = ovf_q || drop || (issue && !issue_ok) || sat;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      credit_q <= FULL;
      ovf_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      credit_q <= credit_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= in_data;
  end
  assign out_vld = count_q != '0;
  assign out_data = mem_q[rd_ptr_q];
  assign count = count_q;
  assign credit_cnt = credit_q;
  assign credit_ok = credit_q != '0;
  assign ovf_err = ovf_q;
endmodule
